// File: rtl/isb_prefetcher.sv
// Irregular Stream Buffer temporal prefetcher: maps each PC's physical address
// stream onto consecutive structural addresses and replays the structural successors.
module isb_prefetcher #(
    parameter int unsigned DEGREE      = 1,
    parameter int unsigned TU_ENTRIES  = 4,
    parameter int unsigned AMC_ENTRIES = 16,
    parameter int unsigned CHUNK       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     v_in,
    input  logic [15:0]              pc,
    input  logic [15:0]              addr,
    output logic [DEGREE-1:0]        pf_valid,
    output logic [16*DEGREE-1:0]     pf_addr
);

    localparam int unsigned IW = $clog2(AMC_ENTRIES);
    localparam int unsigned TW = (TU_ENTRIES > 1) ? $clog2(TU_ENTRIES) : 1;
    localparam logic [15:0] CMASK = 16'(CHUNK - 1);

    // Training unit
    logic [TU_ENTRIES-1:0] tu_v;
    logic [15:0]           tu_pc   [TU_ENTRIES];
    logic [15:0]           tu_last [TU_ENTRIES];
    logic [TW-1:0]         tu_rr;

    // Physical->structural and structural->physical address-map caches
    logic [AMC_ENTRIES-1:0] ps_v;
    logic [15:0]            ps_pa [AMC_ENTRIES];
    logic [15:0]            ps_sa [AMC_ENTRIES];
    logic [AMC_ENTRIES-1:0] sp_v;
    logic [15:0]            sp_sa [AMC_ENTRIES];
    logic [15:0]            sp_pa [AMC_ENTRIES];

    logic [15:0] alloc;

    logic          tu_hit;
    logic [TW-1:0] tu_idx;
    logic [15:0]   last_addr;
    logic [IW-1:0] l_idx;
    logic [IW-1:0] a_idx;
    logic [IW-1:0] s_idx;
    logic          sl_hit;
    logic [15:0]   sl;
    logic          a_hit;
    logic          succ;
    logic          map_new;
    logic          use_alloc;
    logic [15:0]   s_a;

    logic [15:0]          cand;
    logic [IW-1:0]        cidx;
    logic [DEGREE-1:0]    pf_valid_nxt;
    logic [16*DEGREE-1:0] pf_addr_nxt;

    // Training: decide the structural address of this access
    always_comb begin
        tu_hit = 1'b0;
        tu_idx = '0;
        for (int unsigned i = 0; i < TU_ENTRIES; i++) begin
            if (!tu_hit && tu_v[i] && (tu_pc[i] == pc)) begin
                tu_hit = 1'b1;
                tu_idx = TW'(i);
            end
        end
        last_addr = tu_last[tu_idx];
        l_idx     = last_addr[IW-1:0];
        sl_hit    = ps_v[l_idx] && (ps_pa[l_idx] == last_addr);
        sl        = ps_sa[l_idx];
        a_idx     = addr[IW-1:0];
        a_hit     = ps_v[a_idx] && (ps_pa[a_idx] == addr);
        succ      = tu_hit && (addr != last_addr) && sl_hit && ((sl & CMASK) != CMASK);
        map_new   = !a_hit;
        use_alloc = !a_hit && !succ;
        if (a_hit) begin
            s_a = ps_sa[a_idx];
        end else if (succ) begin
            s_a = sl + 16'd1;
        end else begin
            s_a = alloc;
        end
        s_idx = s_a[IW-1:0];
    end

    // Prediction against the pre-update SP contents; never leaves sA's chunk
    always_comb begin
        pf_valid_nxt = '0;
        pf_addr_nxt  = '0;
        cand         = '0;
        cidx         = '0;
        for (int unsigned k = 0; k < DEGREE; k++) begin
            cand = s_a + 16'(k + 1);
            cidx = cand[IW-1:0];
            if ((((cand ^ s_a) & ~CMASK) == 16'd0) && sp_v[cidx] &&
                (sp_sa[cidx] == cand) && (sp_pa[cidx] != addr)) begin
                pf_valid_nxt[k]          = 1'b1;
                pf_addr_nxt[16*k +: 16]  = sp_pa[cidx];
            end
        end
    end

    // Control state and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tu_v     <= '0;
            ps_v     <= '0;
            sp_v     <= '0;
            tu_rr    <= '0;
            alloc    <= '0;
            pf_valid <= '0;
            pf_addr  <= '0;
        end else if (v_in) begin
            pf_valid <= pf_valid_nxt;
            pf_addr  <= pf_addr_nxt;
            if (map_new) begin
                ps_v[a_idx] <= 1'b1;
                sp_v[s_idx] <= 1'b1;
            end
            if (use_alloc) begin
                alloc <= alloc + 16'(CHUNK);
            end
            if (!tu_hit) begin
                tu_v[tu_rr] <= 1'b1;
                tu_rr       <= (tu_rr == TW'(TU_ENTRIES - 1)) ? '0 : tu_rr + TW'(1);
            end
        end else begin
            pf_valid <= '0;
        end
    end

    // Table payloads; meaningless while the matching valid bit is clear
    always_ff @(posedge clk) begin
        if (rst_n && v_in) begin
            if (map_new) begin
                ps_pa[a_idx] <= addr;
                ps_sa[a_idx] <= s_a;
                sp_sa[s_idx] <= s_a;
                sp_pa[s_idx] <= addr;
            end
            if (tu_hit) begin
                tu_last[tu_idx] <= addr;
            end else begin
                tu_pc[tu_rr]   <= pc;
                tu_last[tu_rr] <= addr;
            end
        end
    end

endmodule

// File: tb/tb_isb_prefetcher.sv
// Directed bench: instance a (DEGREE=1, 16-entry AMCs) and instance b
// (DEGREE=2, 32-entry AMCs) are driven one at a time with hand-traced streams.
module tb_isb_prefetcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v_a, v_b;
    logic [15:0] pc_a, addr_a, pc_b, addr_b;
    logic [0:0]  pfv_a;
    logic [15:0] pfa_a;
    logic [1:0]  pfv_b;
    logic [31:0] pfa_b;

    int unsigned passes = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    isb_prefetcher #(.DEGREE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .v_in(v_a), .pc(pc_a), .addr(addr_a),
        .pf_valid(pfv_a), .pf_addr(pfa_a)
    );

    isb_prefetcher #(.DEGREE(2), .AMC_ENTRIES(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .v_in(v_b), .pc(pc_b), .addr(addr_b),
        .pf_valid(pfv_b), .pf_addr(pfa_b)
    );

    // Present one cycle of stimulus to the selected instance, then settle after the edge
    task automatic step(input logic rst, input logic sel_b, input logic v,
                        input logic [15:0] p, input logic [15:0] a);
        @(negedge clk);
        rst_n = !rst;
        v_a   = 1'b0;
        v_b   = 1'b0;
        if (sel_b) begin
            v_b = v; pc_b = p; addr_b = a;
        end else begin
            v_a = v; pc_a = p; addr_a = a;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    logic [15:0] t1_addr [5] = '{16'h0010, 16'h0011, 16'h0010, 16'h0011, 16'h0010};
    logic        t1_v    [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] t1_pf   [5] = '{16'h0000, 16'h0000, 16'h0011, 16'h0000, 16'h0011};

    initial begin
        rst_n = 1'b0;
        v_a = 1'b0; v_b = 1'b0;
        pc_a = '0; addr_a = '0; pc_b = '0; addr_b = '0;

        // Reset and idle
        step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        check("rst_pfv_a", 32'(pfv_a), 32'h0);
        check("rst_pfa_a", 32'(pfa_a), 32'h0);
        check("rst_pfv_b", 32'(pfv_b), 32'h0);
        check("rst_pfa_b", pfa_b, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
            check("idle_pfv_a", 32'(pfv_a), 32'h0);
        end

        // a: pc0 alternates 0x10 (s0) / 0x11 (s1)
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, 16'h0000, t1_addr[i]);
            check("alt_pfv", 32'(pfv_a), 32'(t1_v[i]));
            check("alt_pfa", 32'(pfa_a), 32'(t1_pf[i]));
        end
        step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        check("drop_pfv", 32'(pfv_a), 32'h0);
        check("drop_pfa_hold", 32'(pfa_a), 32'h0011);

        // b: two interleaved PCs land in chunks s0/s1 and s16/s17
        step(1'b1, 1'b1, 1'b0, 16'h0, 16'h0);
        step(1'b0, 1'b1, 1'b1, 16'h0001, 16'h0101);
        check("pc1_a_pfv", 32'(pfv_b), 32'h0);
        step(1'b0, 1'b1, 1'b1, 16'h0002, 16'h0303);
        check("pc2_a_pfv", 32'(pfv_b), 32'h0);
        step(1'b0, 1'b1, 1'b1, 16'h0001, 16'h0202);
        check("pc1_b_pfv", 32'(pfv_b), 32'h0);
        step(1'b0, 1'b1, 1'b1, 16'h0002, 16'h0404);
        check("pc2_b_pfv", 32'(pfv_b), 32'h0);
        step(1'b0, 1'b1, 1'b1, 16'h0001, 16'h0101);
        check("pc1_replay_pfv", 32'(pfv_b), 32'h1);
        check("pc1_replay_pfa", pfa_b, 32'h0000_0202);
        step(1'b0, 1'b1, 1'b1, 16'h0002, 16'h0303);
        check("pc2_replay_pfv", 32'(pfv_b), 32'h1);
        check("pc2_replay_pfa", pfa_b, 32'h0000_0404);

        // b: pc3 trace A,B,C (s32..s34, displacing SP entries of s0..s2), then A
        step(1'b0, 1'b1, 1'b1, 16'h0003, 16'h0505);
        check("abc_a_pfv", 32'(pfv_b), 32'h0);
        step(1'b0, 1'b1, 1'b1, 16'h0003, 16'h0606);
        check("abc_b_pfv", 32'(pfv_b), 32'h0);
        step(1'b0, 1'b1, 1'b1, 16'h0003, 16'h0707);
        check("abc_c_pfv", 32'(pfv_b), 32'h0);
        step(1'b0, 1'b1, 1'b1, 16'h0003, 16'h0505);
        check("abc_replay_pfv", 32'(pfv_b), 32'h3);
        check("abc_replay_pfa", pfa_b, 32'h0707_0606);

        // b: 17-long stream fills s0..s15, 17th access opens chunk s16
        step(1'b1, 1'b1, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 17; i++) begin
            step(1'b0, 1'b1, 1'b1, 16'h0004, 16'h1000 + 16'(i));
            check("chunk_train_pfv", 32'(pfv_b), 32'h0);
        end
        step(1'b0, 1'b1, 1'b1, 16'h0004, 16'h100E);
        check("chunk_edge_pfv", 32'(pfv_b), 32'h1);
        check("chunk_edge_pfa", pfa_b, 32'h0000_100F);
        step(1'b0, 1'b1, 1'b1, 16'h0004, 16'h100F);
        check("chunk_last_pfv", 32'(pfv_b), 32'h0);
        check("chunk_last_pfa", pfa_b, 32'h0);

        // a: 0x20 evicts 0x10 from PS index 0, so 0x10 is remapped as a fresh successor (s2)
        step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        step(1'b0, 1'b0, 1'b1, 16'h0005, 16'h0010);
        step(1'b0, 1'b0, 1'b1, 16'h0005, 16'h0011);
        step(1'b0, 1'b0, 1'b1, 16'h0006, 16'h0020);
        check("conf_evict_pfv", 32'(pfv_a), 32'h0);
        step(1'b0, 1'b0, 1'b1, 16'h0005, 16'h0011);
        check("conf_s1_pfv", 32'(pfv_a), 32'h0);
        step(1'b0, 1'b0, 1'b1, 16'h0005, 16'h0010);
        check("conf_remap_pfv", 32'(pfv_a), 32'h0);
        step(1'b0, 1'b0, 1'b1, 16'h0005, 16'h0011);
        check("conf_succ_pfv", 32'(pfv_a), 32'h1);
        check("conf_succ_pfa", 32'(pfa_a), 32'h0010);

        // a: reset beats a simultaneous access and forgets the trained stream
        step(1'b1, 1'b0, 1'b1, 16'h0005, 16'h0011);
        check("midrst_pfv", 32'(pfv_a), 32'h0);
        check("midrst_pfa", 32'(pfa_a), 32'h0);
        step(1'b0, 1'b0, 1'b1, 16'h0005, 16'h0011);
        check("retrain_1_pfv", 32'(pfv_a), 32'h0);
        step(1'b0, 1'b0, 1'b1, 16'h0005, 16'h0010);
        check("retrain_2_pfv", 32'(pfv_a), 32'h0);
        step(1'b0, 1'b0, 1'b1, 16'h0005, 16'h0011);
        check("retrain_3_pfv", 32'(pfv_a), 32'h1);
        check("retrain_3_pfa", 32'(pfa_a), 32'h0010);

        step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
